// File: rtl/sobel_edge_detect_if.sv
// Pixel-stream bundle between the VGA timing/median-filter side and the
// Sobel edge detector. The master drives the timing counters, the pixel and
// the threshold; the slave returns the gradient magnitude and edge flag.
interface sobel_edge_detect_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [7:0]  pixel_in;
  logic [7:0]  threshold;
  logic [7:0]  magnitude;
  logic        edge_out;
  logic        out_valid;

  modport master (
    output hcount, vcount, pixel_in, threshold,
    input  magnitude, edge_out, out_valid
  );

  modport slave (
    input  hcount, vcount, pixel_in, threshold,
    output magnitude, edge_out, out_valid
  );
endinterface

// File: rtl/sobel_edge_detect.sv
// Sobel edge detector for the half-resolution denoised luma stream.
// One pixel is taken on every even hcount of every even vcount line inside
// the active area. Two line buffers supply the rows above, a 3x3 window
// forms the neighbourhood and a 3-stage pipeline produces |Gx|+|Gy|,
// saturated to 8 bits, plus a thresholded edge flag. Results for border
// pixels, and every result until a fresh frame has started after reset,
// are forced to zero so stale buffer contents never reach the display.
module sobel_edge_detect #(
  parameter int Hor_Addr_Time = 800,
  parameter int Ver_Addr_Time = 600,
  parameter int Width         = Hor_Addr_Time >> 1,
  parameter int Height        = Ver_Addr_Time >> 1
) (
  input  logic                clk,
  input  logic                rst,
  sobel_edge_detect_if.slave  bus
);

  localparam int ColW = $clog2(Width);
  localparam int RowW = $clog2(Height);

  // Strobe decode and half-resolution coordinates
  logic            w_strobe;
  logic [ColW-1:0] w_col;
  logic [RowW-1:0] w_row;
  logic            w_border;

  // Line buffers: lb_a holds the previous row, lb_b the row before that
  logic [7:0] r_lb_a [Width];
  logic [7:0] r_lb_b [Width];
  logic [7:0] w_lb_a_rd;
  logic [7:0] w_lb_b_rd;

  // Frame sync: results are trusted only after a strobe on vcount==0
  logic r_frame_ok;

  // Stage 1: 3x3 window, row 0 is the oldest line, column 2 the newest pixel
  logic [7:0] r_win [3][3];
  logic       r_v1;
  logic       r_force1;

  // Stage 2: signed gradients
  logic signed [10:0] w_gx;
  logic signed [10:0] w_gy;
  logic signed [10:0] r_gx;
  logic signed [10:0] r_gy;
  logic               r_v2;
  logic               r_force2;

  // Stage 3: magnitude, edge flag and valid pulse
  logic [10:0] w_abs_gx;
  logic [10:0] w_abs_gy;
  logic [10:0] w_sum;
  logic [7:0]  w_mag;
  logic        w_edge;
  logic [7:0]  r_magnitude;
  logic        r_edge_out;
  logic        r_out_valid;

  // Zero-extend an unsigned pixel into the signed gradient width.
  function automatic logic signed [10:0] ext8(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  assign w_col = bus.hcount[ColW:1];
  assign w_row = bus.vcount[RowW:1];

  assign w_strobe = ~bus.hcount[0] & ~bus.vcount[0]
                  & (bus.hcount < 11'(Hor_Addr_Time))
                  & (bus.vcount < 11'(Ver_Addr_Time))
                  & ~rst;

  // Pixels too close to the top or left edge have no full neighbourhood.
  assign w_border = (w_col < ColW'(2)) | (w_row < RowW'(2));

  assign w_lb_a_rd = r_lb_a[w_col];
  assign w_lb_b_rd = r_lb_b[w_col];

  // Line buffer update: age the previous row into lb_b, store the new pixel
  // NOTE: buffer contents are deliberately not reset; they are only consumed
  // after a fresh frame has rewritten them, and a resettable array would
  // stop the buffers from mapping onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (w_strobe) begin
      r_lb_b[w_col] <= w_lb_a_rd;
      r_lb_a[w_col] <= bus.pixel_in;
    end
  end

  // Frame sync flag: cleared by reset, set by the first strobe of a frame
  // NOTE: every register is written with <= so all state updates on the edge
  // together; a blocking = here would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_ok <= 1'b0;
    end else if (w_strobe && (bus.vcount == 11'd0)) begin
      r_frame_ok <= 1'b1;
    end
  end

  // Stage 1: shift the window left and load the new right-hand column
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= 8'd0;
        end
      end
      r_v1     <= 1'b0;
      r_force1 <= 1'b0;
    end else begin
      r_v1 <= w_strobe;
      if (w_strobe) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb_b_rd;
        r_win[1][2] <= w_lb_a_rd;
        r_win[2][2] <= bus.pixel_in;
        r_force1    <= w_border | ~r_frame_ok;
      end
    end
  end

  // Sobel kernels on the current window; range is +/-1020, no overflow
  // NOTE: each output of a combinational block is assigned on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    w_gx = (ext8(r_win[0][2]) + (ext8(r_win[1][2]) <<< 1) + ext8(r_win[2][2]))
         - (ext8(r_win[0][0]) + (ext8(r_win[1][0]) <<< 1) + ext8(r_win[2][0]));
    w_gy = (ext8(r_win[2][0]) + (ext8(r_win[2][1]) <<< 1) + ext8(r_win[2][2]))
         - (ext8(r_win[0][0]) + (ext8(r_win[0][1]) <<< 1) + ext8(r_win[0][2]));
  end

  // Stage 2: register the gradients and carry the border/sync force flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_v2     <= 1'b0;
      r_force2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_gx     <= w_gx;
        r_gy     <= w_gy;
        r_force2 <= r_force1;
      end
    end
  end

  // L1 magnitude with saturation to 8 bits and threshold compare
  always_comb begin
    w_abs_gx = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    w_abs_gy = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    w_sum    = w_abs_gx + w_abs_gy;
    w_mag    = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
    w_edge   = (w_mag >= bus.threshold);
  end

  // Stage 3: publish the result; outputs hold their value between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_magnitude <= 8'd0;
      r_edge_out  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        if (r_force2) begin
          r_magnitude <= 8'd0;
          r_edge_out  <= 1'b0;
        end else begin
          r_magnitude <= w_mag;
          r_edge_out  <= w_edge;
        end
      end
    end
  end

  assign bus.magnitude = r_magnitude;
  assign bus.edge_out  = r_edge_out;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Self-checking bench for sobel_edge_detect. The bench drives compressed
// VGA timing (short active lines followed by blanking), keeps an image of
// every strobed pixel and predicts each result straight from the Sobel
// definition on that image. A scoreboard matches every out_valid pulse to
// its strobe three cycles earlier; a vector table checks hand-derived
// values at chosen pixels; short sequences cover reset and strobe gating.
module tb_sobel_edge_detect;

  typedef enum int {PAT_FLAT, PAT_STEP, PAT_RAMP, PAT_RAND} pat_e;

  typedef struct {
    int due;
    int col;
    int row;
    int mag;
    int edg;
  } exp_t;

  typedef struct {
    pat_e pat;
    int   thr;
    int   c_col;
    int   c_row;
    int   mag;
    int   edg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_edge_detect_if bus ();

  sobel_edge_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] img       [300][400];
  int         res_mag   [300][400];
  int         res_edge  [300][400];
  bit         res_seen  [300][400];
  int         pulses_row[300];
  int         total_pulses = 0;
  bit         frame_ok_m = 1'b0;
  int         thr_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pix(input pat_e p, input int col);
    case (p)
      PAT_FLAT: return 100;
      PAT_STEP: return (col < 10) ? 0 : 200;
      PAT_RAMP: return (4 * col) & 255;
      default:  return int'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic int px(input int row, input int col);
    return int'(img[row][col]);
  endfunction

  // Expected result for a strobe at (col,row), straight from the image.
  function automatic exp_t model(input int col, input int row);
    exp_t e;
    int gx, gy, s;
    e.due = 0; e.col = col; e.row = row; e.mag = 0; e.edg = 0;
    if (col >= 2 && row >= 2 && frame_ok_m) begin
      gx = (px(row-2, col) + 2*px(row-1, col) + px(row, col))
         - (px(row-2, col-2) + 2*px(row-1, col-2) + px(row, col-2));
      gy = (px(row, col-2) + 2*px(row, col-1) + px(row, col))
         - (px(row-2, col-2) + 2*px(row-2, col-1) + px(row-2, col));
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      e.mag = (s > 255) ? 255 : s;
      e.edg = (e.mag >= thr_m) ? 1 : 0;
    end
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check("out_valid_due", int'(bus.out_valid), 1);
      if (bus.out_valid === 1'b1) begin
        total_pulses++;
        check($sformatf("magnitude(c%0d,r%0d)", mon_e.col, mon_e.row), int'(bus.magnitude), mon_e.mag);
        check($sformatf("edge_out(c%0d,r%0d)", mon_e.col, mon_e.row), int'(bus.edge_out), mon_e.edg);
        pulses_row[mon_e.row]++;
        if (mon_e.col >= 1 && mon_e.row >= 1) begin
          res_mag [mon_e.row-1][mon_e.col-1] = int'(bus.magnitude);
          res_edge[mon_e.row-1][mon_e.col-1] = int'(bus.edge_out);
          res_seen[mon_e.row-1][mon_e.col-1] = 1'b1;
        end
      end
    end else if (bus.out_valid !== 1'b0) begin
      total_pulses++;
      check("spurious_out_valid", int'(bus.out_valid), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one clock of timing; record and predict any strobe it produces.
  task automatic drive_cycle(input int h, input int v, input pat_e pat, input bit r);
    bit   stb;
    int   p;
    exp_t e;
    bus.hcount = 11'(h);
    bus.vcount = 11'(v);
    rst        = r;
    stb = (h % 2 == 0) && (v % 2 == 0) && (h < 800) && (v < 600) && !r;
    if (stb) begin
      p = pix(pat, h >> 1);
      img[v >> 1][h >> 1] = 8'(p);
      bus.pixel_in = 8'(p);
      e = model(h >> 1, v >> 1);
      e.due = cyc + 3;
      sb.push_back(e);
      if (v == 0) frame_ok_m = 1'b1;
    end else begin
      bus.pixel_in = 8'($urandom_range(0, 255));
    end
  endtask

  // One even line: active sweep over 2*ncols hcount values, then blanking.
  // rst_at >= 0 asserts reset for two cycles starting at that hcount.
  task automatic drive_line(input int v, input int ncols, input pat_e pat, input int rst_at = -1);
    bit   prev_r = 1'b0;
    bit   r;
    exp_t keep[$];
    for (int h = 0; h < 2 * ncols; h++) begin
      r = (rst_at >= 0) && (h == rst_at || h == rst_at + 1);
      tick();
      if (prev_r) begin
        check("rst_magnitude", int'(bus.magnitude), 0);
        check("rst_edge_out", int'(bus.edge_out), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
      end
      if (r && !prev_r) begin
        keep.delete();
        foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
        sb = keep;
        frame_ok_m = 1'b0;
      end
      drive_cycle(h, v, pat, r);
      prev_r = r;
    end
    for (int h = 800; h < 808; h++) begin
      tick();
      drive_cycle(h, v, pat, 1'b0);
    end
  endtask

  // Odd line: pixels change but nothing may be strobed.
  task automatic drive_odd_line(input int v, input int ncols);
    for (int h = 0; h < 2 * ncols; h++) begin
      tick();
      drive_cycle(h, v, PAT_FLAT, 1'b0);
    end
  endtask

  task automatic clear_results(input int nrows, input int ncols);
    for (int r = 0; r < nrows; r++) begin
      pulses_row[r] = 0;
      for (int c = 0; c < ncols; c++) res_seen[r][c] = 1'b0;
    end
  endtask

  task automatic run_frame(input pat_e pat, input int thr, input int nrows, input int ncols);
    thr_m         = thr;
    bus.threshold = 8'(thr);
    clear_results(nrows, ncols);
    for (int r = 0; r < nrows; r++) begin
      drive_line(2 * r, ncols, pat);
      drive_odd_line(2 * r + 1, 8);
    end
  endtask

  vec_t vecs[11];
  int   m0, e0, p0;

  initial begin
    // Hand-derived points; c_col/c_row are the centre pixel coordinates.
    vecs[0]  = '{PAT_STEP, 50,  9, 3, 255, 1};  // Gx=800 across the step
    vecs[1]  = '{PAT_STEP, 50,  5, 3,   0, 0};  // flat dark region
    vecs[2]  = '{PAT_STEP, 50, 10, 2, 255, 1};  // other side of the step
    vecs[3]  = '{PAT_STEP, 50, 11, 2,   0, 0};  // flat bright region
    vecs[4]  = '{PAT_STEP, 50,  9, 0,   0, 0};  // top border forced to 0
    vecs[5]  = '{PAT_RAMP, 32,  7, 3,  32, 1};  // ramp: 4*(8) = 32 >= 32
    vecs[6]  = '{PAT_RAMP, 33,  7, 3,  32, 0};  // 32 < 33
    vecs[7]  = '{PAT_RAMP, 32,  0, 3,   0, 0};  // left border forced to 0
    vecs[8]  = '{PAT_FLAT,  0,  6, 2,   0, 1};  // threshold 0 flags interior
    vecs[9]  = '{PAT_FLAT,  0,  0, 2,   0, 0};  // but never a border pixel
    vecs[10] = '{PAT_STEP, 255, 9, 2, 255, 1};  // saturated value meets 255

    rst           = 1'b1;
    bus.hcount    = '0;
    bus.vcount    = '0;
    bus.pixel_in  = '0;
    bus.threshold = '0;
    repeat (3) tick();
    check("reset_magnitude", int'(bus.magnitude), 0);
    check("reset_edge_out", int'(bus.edge_out), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);

    // Flat field over full-width lines: 400 pulses per even line, all zero.
    run_frame(PAT_FLAT, 10, 3, 400);
    check("pulses_row0", pulses_row[0], 400);
    check("pulses_row2", pulses_row[2], 400);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].pat, vecs[i].thr, 5, 16);
      check($sformatf("vec%0d_seen", i), int'(res_seen[vecs[i].c_row][vecs[i].c_col]), 1);
      check($sformatf("vec%0d_magnitude", i), res_mag[vecs[i].c_row][vecs[i].c_col], vecs[i].mag);
      check($sformatf("vec%0d_edge_out", i), res_edge[vecs[i].c_row][vecs[i].c_col], vecs[i].edg);
    end

    // Random images with random thresholds.
    for (int f = 0; f < 3; f++) begin
      run_frame(PAT_RAND, int'($urandom_range(0, 255)), 8, 24);
    end

    // Strobe gating: odd lines and blanking lines between rows 3 and 4 must
    // not disturb outputs, window or buffers.
    thr_m         = 40;
    bus.threshold = 8'd40;
    clear_results(6, 16);
    for (int r = 0; r < 4; r++) begin
      drive_line(2 * r, 16, PAT_RAND);
      drive_odd_line(2 * r + 1, 16);
    end
    m0 = int'(bus.magnitude);
    e0 = int'(bus.edge_out);
    p0 = total_pulses;
    drive_odd_line(9, 16);
    drive_odd_line(11, 16);
    drive_line(600, 16, PAT_RAND);
    drive_line(602, 16, PAT_RAND);
    check("gate_pulses", total_pulses, p0);
    check("gate_magnitude_held", int'(bus.magnitude), m0);
    check("gate_edge_held", int'(bus.edge_out), e0);
    for (int r = 4; r < 6; r++) begin
      drive_line(2 * r, 16, PAT_RAND);
      drive_odd_line(2 * r + 1, 16);
    end

    // Mid-frame reset at vcount=300 with the step pattern.
    thr_m         = 50;
    bus.threshold = 8'd50;
    clear_results(153, 16);
    for (int r = 0; r < 150; r++) begin
      drive_line(2 * r, 16, PAT_STEP);
      drive_odd_line(2 * r + 1, 4);
    end
    check("pre_reset_step_mag", res_mag[148][9], 255);
    drive_line(300, 16, PAT_STEP, 10);
    drive_odd_line(301, 4);
    drive_line(302, 16, PAT_STEP);
    drive_odd_line(303, 4);
    drive_line(304, 16, PAT_STEP);
    check("post_reset_seen", int'(res_seen[151][9]), 1);
    check("post_reset_forced_mag", res_mag[151][9], 0);
    check("post_reset_forced_edge", res_edge[151][9], 0);
    run_frame(PAT_STEP, 50, 4, 16);
    check("new_frame_seen", int'(res_seen[2][9]), 1);
    check("new_frame_mag", res_mag[2][9], 255);
    check("new_frame_edge", res_edge[2][9], 1);

    repeat (10) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
